asu_dfi_wr_seq: RTL

ASU_DFI_WR_SEQ -- requirements
Module: asu_dfi_wr_seq

---
 rtl/asu_dfi_wr_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/asu_dfi_wr_seq.sv
// DFI write sequencer: buffers write-data beats in an 8-deep FIFO, issues the
// two-cycle WR command on DFI phase 0, then streams the burst after the write latency.
module asu_dfi_wr_seq #(
  parameter int pDRAM_SIZE = 4,
  parameter int pNUM_RANK  = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [4:0]                  wrlat_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [pNUM_RANK-1:0]        req_rank_i,
  input  logic                        req_bl8_i,
  input  logic [8:0]                  req_ca_hi_i,
  input  logic [13:0]                 req_ca2_i,
  input  logic                        wdata_valid_i,
  output logic                        wdata_ready_o,
  input  logic [2*pDRAM_SIZE-1:0]     wdata_i,
  input  logic [pDRAM_SIZE/4-1:0]     wmask_i,
  output logic [pNUM_RANK-1:0]        dfi_cs_n_p0,
  output logic [13:0]                 dfi_address_p0,
  output logic                        dfi_wrdata_en_p0,
  output logic [2*pDRAM_SIZE-1:0]     dfi_wrdata_p0,
  output logic [pDRAM_SIZE/4-1:0]     dfi_wrdata_mask_p0,
  output logic                        busy_o,
  output logic [2:0]                  dbg_state_o
);

  localparam int DW = 2 * pDRAM_SIZE;
  localparam int MW = pDRAM_SIZE / 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD1 = 3'd1,
    S_CMD2 = 3'd2,
    S_WAIT = 3'd3,
    S_DATA = 3'd4
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid may be held across cycles.

  state_t               r_state;
  state_t               w_state_nxt;
  logic [4:0]           r_cnt;
  logic [4:0]           w_cnt_nxt;

  logic [pNUM_RANK-1:0] r_rank;
  logic                 r_bl8;
  logic [8:0]           r_ca_hi;
  logic [13:0]          r_ca2;
  logic [4:0]           r_lat;

  logic [pNUM_RANK-1:0] r_cs_n;
  logic [13:0]          r_addr;
  logic                 r_en;
  logic [DW-1:0]        r_wdata;
  logic [MW-1:0]        r_wmask;

  logic [pNUM_RANK-1:0] w_cs_n_nxt;
  logic [13:0]          w_addr_nxt;
  logic                 w_en_nxt;
  logic                 w_pop;

  logic [DW-1:0]        r_mem_data [8];
  logic [MW-1:0]        r_mem_mask [8];
  logic [2:0]           r_wr_ptr;
  logic [2:0]           r_rd_ptr;
  logic [3:0]           r_count;
  logic                 w_push;
  logic                 w_accept;
  logic [4:0]           w_lat_in;
  logic [4:0]           w_beat_last;

  assign wdata_ready_o = (r_count < 4'd8);
  assign w_push        = wdata_valid_i & wdata_ready_o;
  assign req_ready_o   = (r_state == S_IDLE) & enable_i &
                         (r_count >= (req_bl8_i ? 4'd4 : 4'd8));
  assign w_accept      = req_valid_i & req_ready_o;
  assign w_lat_in      = (wrlat_i < 5'd2) ? 5'd2 : wrlat_i;
  assign w_beat_last   = r_bl8 ? 5'd3 : 5'd7;

  // Outputs are registered from the next state, so each state's DFI values
  // appear in the same cycle the state register holds that state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cs_n_nxt  = '1;
    w_addr_nxt  = '0;
    w_en_nxt    = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CMD1;
          w_cs_n_nxt  = ~req_rank_i;
          w_addr_nxt  = {req_ca_hi_i, 5'b01101};
        end
      end
      S_CMD1: begin
        w_state_nxt = S_CMD2;
        w_addr_nxt  = r_ca2;
      end
      S_CMD2: begin
        w_cnt_nxt = '0;
        if (r_lat == 5'd2) begin
          w_state_nxt = S_DATA;
          w_en_nxt    = 1'b1;
          w_pop       = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 5'(r_lat - 5'd3)) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_en_nxt    = 1'b1;
          w_pop       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_DATA: begin
        if (r_cnt == w_beat_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
          w_en_nxt  = 1'b1;
          w_pop     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cs_n  <= '1;
      r_addr  <= '0;
      r_en    <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rank  <= '0;
      r_bl8   <= 1'b0;
      r_ca_hi <= '0;
      r_ca2   <= '0;
      r_lat   <= 5'd2;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_addr  <= w_addr_nxt;
      r_en    <= w_en_nxt;
      r_wdata <= w_pop ? r_mem_data[r_rd_ptr] : '0;
      r_wmask <= w_pop ? r_mem_mask[r_rd_ptr] : '0;
      if (w_accept) begin
        r_rank  <= req_rank_i;
        r_bl8   <= req_bl8_i;
        r_ca_hi <= req_ca_hi_i;
        r_ca2   <= req_ca2_i;
        r_lat   <= w_lat_in;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= wdata_i;
      r_mem_mask[r_wr_ptr] <= wmask_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 3'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dfi_cs_n_p0        = r_cs_n;
  assign dfi_address_p0     = r_addr;
  assign dfi_wrdata_en_p0   = r_en;
  assign dfi_wrdata_p0      = r_wdata;
  assign dfi_wrdata_mask_p0 = r_wmask;
  assign busy_o             = (r_state != S_IDLE);
  assign dbg_state_o        = r_state;

endmodule
